// File: rtl/pc_sequencer.sv
// Architectural PC owner for the multi-cycle core: issues fetch requests, waits for
// commit, then selects the next PC with trap priority and misalignment redirection.
module pc_sequencer #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    NPC_OP_LENGTH = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_VEC     = DATA_WIDTH'(32'h8000_0000),
  parameter int                    INST_BYTES    = 4,
  parameter int                    ALIGN_BITS    = 2,
  parameter int                    CNT_WIDTH     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     pc_valid,
  input  logic                     pc_ready,
  input  logic                     commit_valid,
  input  logic [NPC_OP_LENGTH-1:0] npc_op,
  input  logic [31:0]              inst,
  input  logic                     branch_taken,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic [DATA_WIDTH-1:0]    csr_target,
  input  logic                     trap_req,
  input  logic [DATA_WIDTH-1:0]    trap_vector,
  output logic                     misalign_fault,
  output logic [DATA_WIDTH-1:0]    misalign_addr,
  output logic [CNT_WIDTH-1:0]     retired_cnt
);

  localparam logic [NPC_OP_LENGTH-1:0] OP_JAL    = NPC_OP_LENGTH'(1);
  localparam logic [NPC_OP_LENGTH-1:0] OP_JALR   = NPC_OP_LENGTH'(2);
  localparam logic [NPC_OP_LENGTH-1:0] OP_BRANCH = NPC_OP_LENGTH'(3);
  localparam logic [NPC_OP_LENGTH-1:0] OP_CSR    = NPC_OP_LENGTH'(4);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] w_seqPc;
  logic [DATA_WIDTH-1:0] w_jImm;
  logic [DATA_WIDTH-1:0] w_bImm;
  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_checkAlign;
  logic                  w_misaligned;
  logic                  w_unused;

  // Opcode and the JALR low bit never influence the target.
  assign w_unused = ^{inst[6:0], alu_result[0]};

  assign w_seqPc = pc + DATA_WIDTH'(INST_BYTES);
  assign w_jImm  = {{(DATA_WIDTH-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign w_bImm  = {{(DATA_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  always_comb begin
    w_target     = w_seqPc;
    w_checkAlign = 1'b1;
    if (trap_req) begin
      w_target     = trap_vector;
      w_checkAlign = 1'b0;
    end else begin
      case (npc_op)
        OP_JAL:    w_target = pc + w_jImm;
        OP_JALR:   w_target = {alu_result[DATA_WIDTH-1:1], 1'b0};
        OP_BRANCH: w_target = branch_taken ? (pc + w_bImm) : w_seqPc;
        OP_CSR:    w_target = csr_target;
        default:   w_target = w_seqPc;
      endcase
    end
  end

  assign w_misaligned = w_checkAlign && (w_target[ALIGN_BITS-1:0] != '0);

  // A misaligned target is replaced by the trap vector but still retires the instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_BOOT;
      pc             <= RESET_VEC;
      pc_valid       <= 1'b0;
      misalign_fault <= 1'b0;
      misalign_addr  <= '0;
      retired_cnt    <= '0;
    end else begin
      misalign_fault <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_state  <= S_REQ;
          pc_valid <= 1'b1;
        end
        S_REQ: begin
          if (pc_ready) begin
            r_state  <= S_EXEC;
            pc_valid <= 1'b0;
          end
        end
        S_EXEC: begin
          if (commit_valid) begin
            r_state     <= S_REQ;
            pc_valid    <= 1'b1;
            retired_cnt <= retired_cnt + CNT_WIDTH'(1);
            if (w_misaligned) begin
              pc             <= trap_vector;
              misalign_fault <= 1'b1;
              misalign_addr  <= w_target;
            end else begin
              pc <= w_target;
            end
          end
        end
        default: begin
          r_state  <= S_BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver issues commits and queues the expected
// next request, a negedge monitor compares each new fetch request against the queue.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h8000_0000;
  localparam logic [31:0] TV = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready = 1'b0;
  logic        commit_valid = 1'b0;
  logic [2:0]  npc_op = '0;
  logic [31:0] inst = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] csr_target = '0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        misalign_fault;
  logic [31:0] misalign_addr;
  logic [63:0] retired_cnt;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .commit_valid(commit_valid), .npc_op(npc_op), .inst(inst), .branch_taken(branch_taken),
    .alu_result(alu_result), .csr_target(csr_target), .trap_req(trap_req),
    .trap_vector(trap_vector), .misalign_fault(misalign_fault),
    .misalign_addr(misalign_addr), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] cnt;
    logic        fault;
    logic [31:0] addr;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        monExp;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mPc;
  logic [63:0] mCnt;
  logic [31:0] mAddr;
  logic        prevValid = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference offsets: unsigned magnitude of the low bits minus the sign weight.
  function automatic int jalOffset(input logic [31:0] ins);
    return int'({ins[19:12], ins[20], ins[30:21], 1'b0}) - (ins[31] ? (1 << 20) : 0);
  endfunction

  function automatic int branchOffset(input logic [31:0] ins);
    return int'({ins[7], ins[30:25], ins[11:8], 1'b0}) - (ins[31] ? 4096 : 0);
  endfunction

  task automatic modelReset();
    exp_t e;
    mPc = RV; mCnt = 0; mAddr = 0;
    sbQ.delete();
    e.pc = RV; e.cnt = 0; e.fault = 1'b0; e.addr = 0;
    sbQ.push_back(e);
  endtask

  task automatic modelCommit(input logic [2:0] op, input logic [31:0] ins, input logic taken,
                             input logic [31:0] alu, input logic [31:0] csr,
                             input logic trap, input logic [31:0] tv);
    exp_t        e;
    logic [31:0] tgt;
    bit          chk;
    chk = 1;
    if (trap) begin
      tgt = tv; chk = 0;
    end else begin
      case (op)
        3'd1:    tgt = mPc + 32'(jalOffset(ins));
        3'd2:    tgt = alu & 32'hFFFF_FFFE;
        3'd3:    tgt = taken ? mPc + 32'(branchOffset(ins)) : mPc + 32'd4;
        3'd4:    tgt = csr;
        default: tgt = mPc + 32'd4;
      endcase
    end
    e.fault = chk && (tgt % 4 != 0);
    if (e.fault) begin
      mAddr = tgt; mPc = tv;
    end else begin
      mPc = tgt;
    end
    mCnt++;
    e.pc = mPc; e.cnt = mCnt; e.addr = mAddr;
    sbQ.push_back(e);
  endtask

  // One full fetch/execute transaction, with optional REQ stall and EXEC wait cycles.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] ins, input logic taken,
                               input logic [31:0] alu, input logic [31:0] csr,
                               input logic trap, input logic [31:0] tv,
                               input int stall, input int execWait);
    int budget;
    budget = 0;
    while (!pc_valid && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!pc_valid) begin
      tests++; fails++;
      $display("[TB] FAIL wait_valid: got pc_valid=0 after %0d cycles, expected 1", budget);
      return;
    end
    for (int k = 0; k < stall; k++) begin
      pc_ready = 1'b0;
      commit_valid = 1'($urandom_range(0, 1));
      npc_op = 3'($urandom); inst = $urandom; alu_result = $urandom; csr_target = $urandom;
      @(posedge clk); #1;
      checkOutput("stall_valid", 64'(pc_valid), 64'd1);
      checkOutput("stall_pc", 64'(pc), 64'(mPc));
      checkOutput("stall_cnt", retired_cnt, mCnt);
    end
    commit_valid = 1'b0;
    pc_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("exec_valid", 64'(pc_valid), 64'd0);
    for (int k = 0; k < execWait; k++) begin
      pc_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checkOutput("exec_hold_pc", 64'(pc), 64'(mPc));
    end
    pc_ready = 1'b0;
    npc_op = op; inst = ins; branch_taken = taken; alu_result = alu;
    csr_target = csr; trap_req = trap; trap_vector = tv;
    commit_valid = 1'b1;
    modelCommit(op, ins, taken, alu, csr, trap, tv);
    @(posedge clk); #1;
    commit_valid = 1'b0;
    trap_req = 1'b0;
    checkOutput("commit_latency", 64'(pc_valid), 64'd1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prevValid = 1'b0;
    end else begin
      if (pc_valid && !prevValid) begin
        if (sbQ.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_req: got request at pc 0x%0h, expected none", pc);
        end else begin
          monExp = sbQ.pop_front();
          checkOutput("req_pc", 64'(pc), 64'(monExp.pc));
          checkOutput("req_retired_cnt", retired_cnt, monExp.cnt);
          checkOutput("req_misalign_fault", 64'(misalign_fault), 64'(monExp.fault));
          checkOutput("req_misalign_addr", 64'(misalign_addr), 64'(monExp.addr));
        end
      end else if (misalign_fault) begin
        tests++; fails++;
        $display("[TB] FAIL stray_fault: got misalign_fault=1, expected 0");
      end
      prevValid = pc_valid;
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pc"}, 64'(pc), 64'(RV));
    checkOutput({tag, "_valid"}, 64'(pc_valid), 64'd0);
    checkOutput({tag, "_cnt"}, retired_cnt, 64'd0);
    checkOutput({tag, "_fault"}, 64'(misalign_fault), 64'd0);
    checkOutput({tag, "_addr"}, 64'(misalign_addr), 64'd0);
  endtask

  initial begin
    modelReset();
    #22 reset = 1'b0;
    #1 checkResetValues("reset");
    @(posedge clk); #1;
    checkOutput("boot_valid", 64'(pc_valid), 64'd1);

    applyStimulus(3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, TV, 5, 0);
    checkOutput("next_pc", 64'(pc), 64'h8000_0004);
    checkOutput("next_cnt", retired_cnt, 64'd1);
    for (int i = 0; i < 3; i++) applyStimulus(3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, TV, 0, 0);
    applyStimulus(3'd1, 32'h0080_006F, 1'b0, 32'h0, 32'h0, 1'b0, TV, 0, 1);
    checkOutput("jal_pc", 64'(pc), 64'h8000_0018);
    applyStimulus(3'd4, 32'h0, 1'b0, 32'h0, 32'h8000_0010, 1'b0, TV, 0, 0);
    applyStimulus(3'd3, 32'hFE00_0EE3, 1'b1, 32'h0, 32'h0, 1'b0, TV, 1, 0);
    checkOutput("branch_taken_pc", 64'(pc), 64'h8000_000C);
    applyStimulus(3'd4, 32'h0, 1'b0, 32'h0, 32'h8000_0010, 1'b0, TV, 0, 0);
    applyStimulus(3'd3, 32'hFE00_0EE3, 1'b0, 32'h0, 32'h0, 1'b0, TV, 0, 2);
    checkOutput("branch_not_taken_pc", 64'(pc), 64'h8000_0014);
    applyStimulus(3'd2, 32'h0, 1'b0, 32'h8000_0101, 32'h0, 1'b0, TV, 0, 0);
    checkOutput("jalr_pc", 64'(pc), 64'h8000_0100);
    checkOutput("jalr_no_fault", 64'(misalign_fault), 64'd0);
    applyStimulus(3'd2, 32'h0, 1'b0, 32'h8000_0102, 32'h0, 1'b0, TV, 0, 0);
    checkOutput("misalign_pc", 64'(pc), 64'(TV));
    checkOutput("misalign_fault", 64'(misalign_fault), 64'd1);
    checkOutput("misalign_addr", 64'(misalign_addr), 64'h8000_0102);
    applyStimulus(3'd4, 32'h0, 1'b0, 32'h0, 32'h8000_0200, 1'b0, TV, 0, 0);
    applyStimulus(3'd1, 32'h0080_006F, 1'b0, 32'h0, 32'h0, 1'b1, TV, 0, 0);
    checkOutput("trap_jal_pc", 64'(pc), 64'(TV));
    applyStimulus(3'd4, 32'h0, 1'b0, 32'h0, 32'h8000_0200, 1'b0, TV, 0, 0);
    applyStimulus(3'd4, 32'h0, 1'b0, 32'h0, 32'h8000_0302, 1'b1, TV, 0, 0);
    checkOutput("trap_csr_pc", 64'(pc), 64'(TV));
    checkOutput("trap_csr_no_fault", 64'(misalign_fault), 64'd0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
                    ($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFC,
                    $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Abort a transaction in EXEC with a commit already presented.
    while (!pc_valid) begin @(posedge clk); #1; end
    pc_ready = 1'b1;
    @(posedge clk); #1;
    pc_ready = 1'b0;
    npc_op = 3'd4; csr_target = 32'h1234_5678; commit_valid = 1'b1;
    #2 reset = 1'b1;
    #1 checkResetValues("async_reset");
    commit_valid = 1'b0;
    modelReset();
    @(posedge clk); #1;
    reset = 1'b0;
    #1 checkOutput("post_reset_boot_valid", 64'(pc_valid), 64'd0);
    applyStimulus(3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, TV, 0, 0);
    checkOutput("post_reset_pc", 64'(pc), 64'h8000_0004);
    checkOutput("post_reset_cnt", retired_cnt, 64'd1);

    @(posedge clk); #1;
    checkOutput("sb_drain", 64'(sbQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
